// File: rtl/song_sequencer_pkg.sv
// Shared state encodings and sizing for the lab8 song record/playback controller.
package lab8_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int NOTE_MEM_DEPTH = 2 ** ADDR_W_DEF;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] P_LOAD  = 3'd2;
  localparam logic [2:0] P_START = 3'd3;
  localparam logic [2:0] P_WAIT  = 3'd4;
  localparam logic [2:0] P_GAP   = 3'd5;

  function automatic logic is_play(input logic [2:0] st);
    return (st == P_LOAD) || (st == P_START) || (st == P_WAIT) || (st == P_GAP);
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control/status bundle between the song sequencer and its UART, BRAM and envelope neighbours.
interface song_sequencer_if
  import lab8_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              toggle;
  logic              rx_dv;
  logic              env_done;
  logic              writing;
  logic              playing;
  logic              mem_we;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_max;
  logic              note_start;
  logic              mem_full;

  modport slave (
    input  toggle, rx_dv, env_done,
    output writing, playing, mem_we, addr, addr_max, note_start, mem_full
  );

  modport master (
    output toggle, rx_dv, env_done,
    input  writing, playing, mem_we, addr, addr_max, note_start, mem_full
  );

endinterface

// File: rtl/song_sequencer_gap_timer.sv
// Loadable down-counter that flags the last clock of an inter-note silence.
module gap_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load of N yields N enabled cycles, the last of which raises done.
  assign done = en && (count_q == WIDTH'(1));

endmodule

// File: rtl/song_sequencer.sv
// Record/playback controller for the UART-fed note memory.
// Define SONG_LOOP_EN to repeat the song until toggle instead of stopping at its end.
module song_sequencer
  import lab8_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  song_sequencer_if.slave     bus
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_max_q, addr_max_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_full_q, mem_full_d;
  logic              wait_armed_q, wait_armed_d;
  logic              writing, mem_we, advance, gap_load, gap_done;

  assign writing = (state_q == WRITE);
  assign mem_we  = writing & bus.rx_dv & ~mem_full_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    addr_max_d   = addr_max_q;
    count_d      = count_q;
    mem_full_d   = mem_full_q;
    advance      = 1'b0;
    gap_load     = 1'b0;
    // env_done is only honoured once P_WAIT has been occupied for a full cycle.
    wait_armed_d = (state_q == P_WAIT);

    case (state_q)
      IDLE: begin
        if (bus.toggle) begin
          state_d    = WRITE;
          addr_d     = '0;
          count_d    = '0;
          mem_full_d = 1'b0;
        end
      end
      WRITE: begin
        if (mem_we) begin
          count_d = count_q + (ADDR_W + 1)'(1);
          if (addr_q != '1) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            mem_full_d = 1'b1;
          end
        end
        if (bus.toggle) begin
          if (count_d == '0) begin
            state_d = IDLE;
          end else begin
            addr_max_d = ADDR_W'(count_d - (ADDR_W + 1)'(1));
            addr_d     = '0;
            state_d    = P_LOAD;
          end
        end
      end
      P_LOAD:  state_d = P_START;
      P_START: state_d = P_WAIT;
      P_WAIT: begin
        if (wait_armed_q && bus.env_done) begin
          if (GAP_CYCLES == 0) begin
            advance = 1'b1;
          end else begin
            gap_load = 1'b1;
            state_d  = P_GAP;
          end
        end
      end
      P_GAP: begin
        if (gap_done) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (addr_q != addr_max_q) begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = P_LOAD;
      end else begin
        addr_d  = '0;
`ifdef SONG_LOOP_EN
        state_d = P_LOAD;
`else
        state_d = IDLE;
`endif
      end
    end

    // Toggle during playback overrides any same-cycle env_done or gap expiry.
    if (bus.toggle && is_play(state_q)) begin
      state_d    = WRITE;
      addr_d     = '0;
      count_d    = '0;
      mem_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      addr_max_q   <= '0;
      count_q      <= '0;
      mem_full_q   <= 1'b0;
      wait_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      addr_max_q   <= addr_max_d;
      count_q      <= count_d;
      mem_full_q   <= mem_full_d;
      wait_armed_q <= wait_armed_d;
    end
  end

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      gap_timer #(
        .WIDTH (GAP_W)
      ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .en       (state_q == P_GAP),
        .load_val (GAP_W'(GAP_CYCLES)),
        .done     (gap_done)
      );
    end else begin : g_no_gap
      logic unused_gap_load;
      assign unused_gap_load = gap_load;
      assign gap_done        = 1'b0;
    end
  endgenerate

  assign bus.writing    = writing;
  assign bus.playing    = is_play(state_q);
  assign bus.mem_we     = mem_we;
  assign bus.addr       = addr_q;
  assign bus.addr_max   = addr_max_q;
  assign bus.note_start = (state_q == P_START);
  assign bus.mem_full   = mem_full_q;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Record/playback controller for the UART-fed note memory.
- In record mode it turns received UART bytes into BRAM writes at increasing addresses.
- In play mode it walks the memory, sends one note_start pulse per note to the envelope generator, and waits for env_done before advancing.
- It sits between button_pulse/uart_rx_vlog and rams_sp_wf/envel_gen in the lab8 top level.

Parameters:
- ADDR_W, 10: note-memory address width; capacity is 2**ADDR_W notes.
- GAP_CYCLES, 0: idle clocks between env_done and loading the next note; 0 disables the gap.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- toggle  in  1  one-cycle pulse from the debounced button; switches between modes.
- rx_dv  in  1  one-cycle pulse; a UART byte is valid.
- env_done  in  1  envelope for the current note has finished.
- writing  out  1  high while in record mode; drives led1 and ~ampSD.
- playing  out  1  high in any play state.
- mem_we  out  1  BRAM write enable.
- addr  out  ADDR_W  BRAM address, registered.
- addr_max  out  ADDR_W  last valid note address of the stored song.
- note_start  out  1  one-cycle pulse that starts a note.
- mem_full  out  1  record mode has filled the memory.

Behaviour:
- Reset state: IDLE. writing=0, playing=0, addr=0, addr_max=0, note_start=0, mem_full=0, internal count=0, gap counter=0.
- mem_we is combinational: writing & rx_dv & ~mem_full. All other outputs are registered or Moore outputs.
- States: IDLE, WRITE, P_LOAD, P_START, P_WAIT, P_GAP.
- IDLE:
  - On toggle: go to WRITE; addr←0, count←0, mem_full←0.
- WRITE:
  - On mem_we: count←count+1 (count is ADDR_W+1 bits).
  - On mem_we with addr≠all-ones: addr←addr+1.
  - On mem_we with addr=all-ones: addr holds and mem_full←1. Later rx_dv pulses are ignored.
- Leaving WRITE, on toggle:
  - Use count_next, which includes any write in the same cycle.
  - If count_next=0: go to IDLE.
  - Otherwise: addr_max←count_next−1, addr←0, go to P_LOAD.
- P_LOAD: lasts exactly 1 cycle to cover the BRAM synchronous-read latency, then goes to P_START.
- P_START: note_start=1 for this single cycle, then P_WAIT.
- P_WAIT:
  - env_done is ignored in the entry cycle.
  - On any later cycle with env_done=1: if GAP_CYCLES=0, advance; otherwise load the gap counter and go to P_GAP.
- P_GAP: counts GAP_CYCLES clocks, then advances.
- Advance:
  - If addr≠addr_max: addr←addr+1, go to P_LOAD.
  - If addr=addr_max: end-of-song handling (see Optional Feature).
- toggle in any P_* state: abort with no further note_start, then the same action as toggle in IDLE (WRITE, addr←0, count←0, mem_full←0).
- toggle and env_done in the same cycle: toggle wins.
- toggle and rx_dv in the same cycle in WRITE: the byte is written and counted, then the mode switches.
- addr_max holds its value across WRITE until the next exit from WRITE.
- A reset asserted mid-operation returns to the reset state on the next edge. BRAM contents are untouched.
- Throughput: per note, P_LOAD (1) + P_START (1) + envelope time + GAP_CYCLES + 1.

Optional Feature:
- Macro: SONG_LOOP_EN.
- Defined: at addr=addr_max, advance sets addr←0 and goes to P_LOAD; the song repeats until toggle.
- Undefined: at addr=addr_max, advance sets addr←0 and goes to IDLE with playing=0. The next toggle enters WRITE; the song is kept in memory but not replayed.

Decomposition:
- Package lab8_pkg:
  - state enum (IDLE, WRITE, P_LOAD, P_START, P_WAIT, P_GAP).
  - ADDR_W default.
  - NOTE_MEM_DEPTH = 2**ADDR_W.
- One natural sub-module: gap_timer, a loadable down-counter with a done flag, instantiated only when GAP_CYCLES>0.

Test Plan:
- Reset then toggle; 3 rx_dv pulses (bytes 0x41,0x42,0x43); toggle → mem_we at addr 0,1,2; addr_max=2; after 1 P_LOAD cycle, note_start pulses with addr=0.
- Playback, SONG_LOOP_EN defined, addr_max=2, env_done pulsed 5 cycles after each note_start → addr sequence 0,1,2,0,…; exactly one note_start per note; note_start lands 2 cycles after each env_done.
- Playback, SONG_LOOP_EN undefined → after env_done at addr=2: state IDLE, playing=0, addr=0, no further note_start.
- Empty song: toggle, toggle with no rx_dv → returns to IDLE, note_start never asserted, addr_max unchanged.
- Overflow, ADDR_W=3: 10 rx_dv pulses → 8 writes (addr 0–7), mem_full=1 after the 8th, mem_we=0 for pulses 9–10; toggle → addr_max=7.
- Same-cycle events: toggle with rx_dv on the 2nd byte → 2 writes, addr_max=1. toggle with env_done in P_WAIT → enters WRITE, addr=0, no note_start. GAP_CYCLES=4 → note_start lands 6 cycles after env_done.
